// File: rtl/branch_resolve_if.sv
// Execute-to-fetch bundle for the branch resolve unit.
// The slave side is the resolver; the master side is the execute/fetch environment.
interface branch_resolve_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             in_is_jump;
  logic [2:0]       in_funct3;
  logic [XLEN-1:0]  in_pc;
  logic [XLEN-1:0]  in_imm;
  logic             in_pred_taken;
  logic             alu_zero;
  logic             alu_neg;
  logic             alu_carry;
  logic             alu_ovf;
  logic             out_valid;
  logic             out_ready;
  logic             out_taken;
  logic [XLEN-1:0]  out_next_pc;
  logic             out_mispredict;
  logic             out_illegal;
  logic             out_misalign;
  logic [CNT_W-1:0] stat_branches;
  logic [CNT_W-1:0] stat_taken;
  logic [CNT_W-1:0] stat_mispred;

  modport slave (
    input  in_valid, in_is_jump, in_funct3, in_pc, in_imm, in_pred_taken,
    input  alu_zero, alu_neg, alu_carry, alu_ovf, out_ready,
    output in_ready, out_valid, out_taken, out_next_pc, out_mispredict,
    output out_illegal, out_misalign, stat_branches, stat_taken, stat_mispred
  );

  modport master (
    output in_valid, in_is_jump, in_funct3, in_pc, in_imm, in_pred_taken,
    output alu_zero, alu_neg, alu_carry, alu_ovf, out_ready,
    input  in_ready, out_valid, out_taken, out_next_pc, out_mispredict,
    input  out_illegal, out_misalign, stat_branches, stat_taken, stat_mispred
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves RV32I conditional branches and JAL from ALU compare flags, queues the
// results in a 2-entry FIFO for fetch, and keeps saturating branch statistics.
module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  branch_resolve_if.slave bus
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  typedef struct packed {
    logic            taken;
    logic [XLEN-1:0] next_pc;
    logic            mispred;
    logic            illegal;
    logic            misalign;
  } res_t;

  function automatic logic cond_taken(input logic [2:0] f3, input logic z, input logic n,
                                      input logic c, input logic v);
    logic t;
    case (f3)
      3'b000:  t = z;
      3'b001:  t = !z;
      3'b100:  t = n ^ v;
      3'b101:  t = !(n ^ v);
      3'b110:  t = !c;
      3'b111:  t = c;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? v + {{(CNT_W-1){1'b0}}, 1'b1} : v;
  endfunction

  state_t           state_q, state_d;
  logic             rd_ptr_q, wr_ptr_q;
  res_t             mem_q [2];
  res_t             res_d;
  res_t             head;
  logic             push, pop;
  logic             in_ready, out_valid;
  logic [XLEN-1:0]  target, seq_pc;
  logic [CNT_W-1:0] br_cnt_q, tk_cnt_q, mp_cnt_q;

  // Resolve stage: combinational result of the op presented this cycle
  always_comb begin
    target           = bus.in_pc + bus.in_imm;
    seq_pc           = bus.in_pc + {{(XLEN-3){1'b0}}, 3'd4};
    res_d.illegal    = !bus.in_is_jump && (bus.in_funct3[2:1] == 2'b01);
    res_d.taken      = bus.in_is_jump ||
                       (!res_d.illegal && cond_taken(bus.in_funct3, bus.alu_zero,
                                                     bus.alu_neg, bus.alu_carry, bus.alu_ovf));
    res_d.next_pc    = res_d.taken ? target : seq_pc;
    res_d.mispred    = res_d.taken != bus.in_pred_taken;
    res_d.misalign   = res_d.taken && (target[1:0] != 2'b00);
  end

  // Queue occupancy FSM; ready depends only on registered state
  always_comb begin
    state_d   = state_q;
    in_ready  = (state_q != FULL);
    out_valid = (state_q != EMPTY);
    push      = bus.in_valid && in_ready;
    pop       = out_valid && bus.out_ready;
    case (state_q)
      EMPTY:   if (push) state_d = ONE;
      ONE:     if (push && !pop) state_d = FULL;
               else if (!push && pop) state_d = EMPTY;
      FULL:    if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      br_cnt_q <= '0;
      tk_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      if (push) wr_ptr_q <= !wr_ptr_q;
      if (pop)  rd_ptr_q <= !rd_ptr_q;
      br_cnt_q <= sat_inc(br_cnt_q, push);
      tk_cnt_q <= sat_inc(tk_cnt_q, push && res_d.taken);
      mp_cnt_q <= sat_inc(mp_cnt_q, push && res_d.mispred);
    end
  end

  // Entry storage is not reset; outputs are masked while the queue is empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= res_d;
  end

  // Output stage: head of queue, forced to zero when empty
  always_comb begin
    head = out_valid ? mem_q[rd_ptr_q] : '0;
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = out_valid;
  assign bus.out_taken      = head.taken;
  assign bus.out_next_pc    = head.next_pc;
  assign bus.out_mispredict = head.mispred;
  assign bus.out_illegal    = head.illegal;
  assign bus.out_misalign   = head.misalign;
  assign bus.stat_branches  = br_cnt_q;
  assign bus.stat_taken     = tk_cnt_q;
  assign bus.stat_mispred   = mp_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed ops push expected results,
// an independent monitor pops and compares on every output handshake.
module tb_branch_resolve_unit;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  typedef struct {
    logic        taken;
    logic [31:0] npc;
    logic        mis;
    logic        ill;
    logic        mal;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  branch_resolve_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();
  branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: the handshake happens at the following posedge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("taken",      {31'd0, bus.out_taken},      {31'd0, e.taken});
          chk("next_pc",    bus.out_next_pc,             e.npc);
          chk("mispredict", {31'd0, bus.out_mispredict}, {31'd0, e.mis});
          chk("illegal",    {31'd0, bus.out_illegal},    {31'd0, e.ill});
          chk("misalign",   {31'd0, bus.out_misalign},   {31'd0, e.mal});
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input logic j, input logic [2:0] f3, input logic [31:0] pc,
                      input logic [31:0] imm, input logic pred, input logic [3:0] znca,
                      input logic et, input logic [31:0] enpc, input logic emis,
                      input logic eill, input logic emal, input bit track = 1'b1);
    int w;
    exp_t e;
    bus.in_is_jump = j;   bus.in_funct3 = f3;  bus.in_pc = pc;  bus.in_imm = imm;
    bus.in_pred_taken = pred;
    {bus.alu_zero, bus.alu_neg, bus.alu_carry, bus.alu_ovf} = znca;
    bus.in_valid = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!bus.in_ready && w < 100);
    if (!bus.in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    if (track) begin
      e.taken = et; e.npc = enpc; e.mis = emis; e.ill = eill; e.mal = emal;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 50) begin
      @(posedge clk);
      w++;
    end
    chk("drain_left", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic stats_chk(input int b, input int t, input int m);
    @(negedge clk);
    chk("stat_branches", {28'd0, bus.stat_branches}, b);
    chk("stat_taken",    {28'd0, bus.stat_taken},    t);
    chk("stat_mispred",  {28'd0, bus.stat_mispred},  m);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_is_jump = 1'b0; bus.in_funct3 = 3'd0;
    bus.in_pc = '0; bus.in_imm = '0; bus.in_pred_taken = 1'b0;
    bus.alu_zero = 1'b0; bus.alu_neg = 1'b0; bus.alu_carry = 1'b0; bus.alu_ovf = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("rst_next_pc",   bus.out_next_pc,        32'd0);
    @(posedge clk);
    #1;
    stats_chk(0, 0, 0);

    // Test 1: BEQ taken, latency 1
    send(1'b0, 3'b000, 32'h100, 32'h20, 1'b0, 4'b1000, 1'b1, 32'h120, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("t1_out_valid_latency", {31'd0, bus.out_valid}, 32'd1);
    @(posedge clk);
    #1;

    // Test 2: signed/unsigned conditions
    send(1'b0, 3'b100, 32'h200, 32'h40, 1'b1, 4'b0001, 1'b1, 32'h240, 1'b0, 1'b0, 1'b0);
    send(1'b0, 3'b111, 32'h300, 32'h80, 1'b0, 4'b0000, 1'b0, 32'h304, 1'b0, 1'b0, 1'b0);
    send(1'b0, 3'b110, 32'h400, 32'hFFFF_FFF0, 1'b0, 4'b0000, 1'b1, 32'h3F0, 1'b1, 1'b0, 1'b0);
    drain();
    stats_chk(4, 3, 2);

    // Test 3: backpressure, third op held, FIFO order
    bus.out_ready = 1'b0;
    send(1'b0, 3'b001, 32'h500, 32'h10, 1'b1, 4'b0000, 1'b1, 32'h510, 1'b0, 1'b0, 1'b0);
    send(1'b0, 3'b101, 32'h600, 32'h10, 1'b1, 4'b0100, 1'b0, 32'h604, 1'b1, 1'b0, 1'b0);
    fork
      send(1'b0, 3'b110, 32'h700, 32'h10, 1'b0, 4'b0010, 1'b0, 32'h704, 1'b0, 1'b0, 1'b0);
    join_none
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_in_ready_full", {31'd0, bus.in_ready},  32'd0);
      chk("t3_hold_valid",    {31'd0, bus.out_valid}, 32'd1);
      chk("t3_hold_next_pc",  bus.out_next_pc,        32'h510);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait fork;
    drain();
    stats_chk(7, 4, 3);

    // Test 4: wrap, misalign, illegal
    send(1'b1, 3'b000, 32'hFFFF_FFFC, 32'h8, 1'b1, 4'b0000, 1'b1, 32'h4, 1'b0, 1'b0, 1'b0);
    send(1'b1, 3'b000, 32'hFFFF_FFFC, 32'h6, 1'b1, 4'b0000, 1'b1, 32'h2, 1'b0, 1'b0, 1'b1);
    send(1'b0, 3'b010, 32'h200, 32'h10, 1'b0, 4'b1000, 1'b0, 32'h204, 1'b0, 1'b1, 1'b0);
    send(1'b0, 3'b001, 32'hFFFF_FFFC, 32'h10, 1'b0, 4'b1000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    send(1'b0, 3'b011, 32'h800, 32'h10, 1'b1, 4'b1111, 1'b0, 32'h804, 1'b1, 1'b1, 1'b0);
    send(1'b0, 3'b000, 32'h900, 32'h6, 1'b0, 4'b0000, 1'b0, 32'h904, 1'b0, 1'b0, 1'b0);
    drain();
    stats_chk(13, 6, 4);

    // Test 5: reset with two entries queued and an op presented
    bus.out_ready = 1'b0;
    send(1'b1, 3'b000, 32'hA00, 32'h10, 1'b0, 4'b0000, 1'b1, 32'hA10, 1'b1, 1'b0, 1'b0, 1'b0);
    send(1'b1, 3'b000, 32'hB00, 32'h10, 1'b0, 4'b0000, 1'b1, 32'hB10, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("t5_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("t5_next_pc",   bus.out_next_pc,        32'd0);
    chk("t5_taken",     {31'd0, bus.out_taken}, 32'd0);
    chk("t5_stats",     {20'd0, bus.stat_branches, bus.stat_taken, bus.stat_mispred}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("t5_post_valid", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk);
    #1;

    // Test 6: counter saturation with 4-bit counters
    for (int i = 0; i < 17; i++)
      send(1'b1, 3'b000, 32'h1000, 32'h10, 1'b1, 4'b0000, 1'b1, 32'h1010, 1'b0, 1'b0, 1'b0);
    drain();
    stats_chk(15, 15, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
